uart_rx_fifo: RTL

Serial receive front end for the system's `ser_rxd` pin, sitting directly upstream of the device block's bus-side read logic. It recovers 8-bit asynchronous frames from the raw line and buffers them in a first-word-fall-through FIFO. It exposes the FIFO plus sticky error flags and a level interrupt request for the device/interrupt logic to consume.

---
 rtl/uart_rx_fifo.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 (or 8E1 with UART_RX_PARITY_EN) serial receiver feeding a first-word-fall-through byte FIFO.
// Latency: byte pushed 2 + CLK_DIV/2 + 9*CLK_DIV cycles after the line falls (+CLK_DIV with parity); head visible next cycle.
// Backpressure: none on the line; a byte arriving into a full FIFO is dropped and flags overrun unless popped that same cycle.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_rxd,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  irq_req_o
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0]   HALF_LAST = BAUD_W'(CLK_DIV / 2 - 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                  r_state, w_state_nxt;
  logic                    r_sync1, r_sync2, r_rxd_prev;
  logic [BAUD_W-1:0]       r_baud_cnt;
  logic [2:0]              r_bit_cnt;
  logic [7:0]              r_shift;
  logic [7:0]              r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic                    r_empty, r_full;
  logic                    r_overrun, r_frame_err;

  logic w_rxd_s, w_fall, w_baud_done, w_half_done;
  logic w_baud_clr, w_shift_en, w_push, w_set_ferr;
  logic w_pop, w_wr_en, w_set_ovr;
  logic [DEPTH_LOG2:0] w_count_nxt;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit, r_parity_err;
  logic w_par_en, w_set_perr, w_par_bad;
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign w_par_bad = ^{r_shift, r_par_bit};
`endif

  assign w_rxd_s     = r_sync2;
  assign w_fall      = r_rxd_prev & ~r_sync2;
  assign w_baud_done = (r_baud_cnt == BAUD_LAST);
  assign w_half_done = (r_baud_cnt == HALF_LAST);

  // Two-flop synchronizer plus one delayed copy for start-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync1    <= ser_rxd;
      r_sync2    <= r_sync1;
      r_rxd_prev <= r_sync2;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Frame FSM next state and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_clr  = 1'b0;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_set_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en    = 1'b0;
    w_set_perr  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_baud_clr  = 1'b1;
        end
      end
      S_START: begin
        // Mid-bit check rejects short glitches and re-centres the baud counter.
        if (w_half_done) begin
          w_baud_clr  = 1'b1;
          w_state_nxt = w_rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_clr = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_baud_done) begin
          w_baud_clr  = 1'b1;
          w_par_en    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_clr  = 1'b1;
          w_state_nxt = S_IDLE;
          if (!w_rxd_s) w_set_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (w_par_bad) w_set_perr = 1'b1;
`endif
          else w_push = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Baud/bit counters and the LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_baud_cnt <= w_baud_clr ? '0 : r_baud_cnt + BAUD_W'(1);
      if (w_shift_en) begin
        r_shift   <= {w_rxd_s, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end else if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit, checked at the stop sample.
  always_ff @(posedge clk) begin
    if (rst)           r_par_bit <= 1'b0;
    else if (w_par_en) r_par_bit <= w_rxd_s;
  end
`endif

  // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs.
  assign w_pop     = rd_en & ~r_empty;
  assign w_wr_en   = w_push & (~r_full | w_pop);
  assign w_set_ovr = w_push & r_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + (DEPTH_LOG2 + 1)'(1);
      2'b01:   w_count_nxt = r_count - (DEPTH_LOG2 + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO pointers, occupancy and registered empty/full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == DEPTH_CNT);
    end
  end

  // FIFO storage; contents need no reset because dout is masked while empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
  end

  // Sticky error flags; a set event in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= (r_overrun   & ~clr_err) | w_set_ovr;
      r_frame_err <= (r_frame_err & ~clr_err) | w_set_ferr;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity error flag.
  always_ff @(posedge clk) begin
    if (rst) r_parity_err <= 1'b0;
    else     r_parity_err <= (r_parity_err & ~clr_err) | w_set_perr;
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign dout      = r_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty     = r_empty;
  assign full      = r_full;
  assign count     = r_count;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign irq_req_o = ~r_empty;

endmodule
